decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Second pipeline stage of the 16-bit core. Sits directly downstream of the fetch stage.
- Consumes the 25-bit fetch bundle {pc[8:0], instr[15:0]}.
- Holds the 16x16 architectural register file, with a writeback port from the last stage.
- Produces one registered, fully decoded operation per cycle for execute.
- Drops the bundle on branch/jump redirect and latches halt.

Parameters:
- AW, 9, PC / instruction-address width (512-entry instruction memory).
- DW, 16, data and instruction width.
- NREG, 16, register count; r0 reads as zero.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- inst  in  25  fetch bundle: [24:16] pc, [15:0] instr; all-zero = bubble
- do_branch  in  1  redirect from execute this cycle; flush
- do_jump  in  1  redirect from execute this cycle; flush
- stall  in  1  hold all outputs; do not consume inst
- wb_en  in  1  register write enable
- wb_idx  in  4  write index
- wb_data  in  16  write data
- d_valid  out  1  decoded op valid
- d_pc  out  9  pc of op
- d_op  out  4  opcode instr[15:12]
- d_rd  out  4  destination instr[11:8]
- d_a  out  16  R[instr[11:8]]
- d_b  out  16  R[instr[7:4]] (R-type/bgt) or zero-extended instr[7:0] (addi/subi)
- d_we  out  1  op writes d_rd
- d_is_branch  out  1  bgt
- d_is_jump  out  1  jmp
- d_target  out  9  branch/jump target
- halted  out  1  sticky halt

Behaviour:
- Reset (rst low, asynchronous): all d_* = 0; halted = 0; all registers = 0.
- Opcode map:
  - 0000 nop
  - 0001 add
  - 0010 sub
  - 0011 and
  - 0100 or
  - 0101 addi
  - 0110 subi
  - 1101 bgt
  - 1110 jmp
  - 16'hFFFF halt
  - Other encodings decode as nop with d_valid=1, d_we=0.
- d_we = 1 for add/sub/and/or/addi/subi when d_rd != 0; 0 otherwise.
- bgt ra=instr[11:8], rb=instr[7:4], off=instr[3:0]:
  - d_target = pc + sign_extend(off), modulo 512 (wraps).
  - Compare is signed, done in execute.
- jmp: d_target = instr[8:0] (absolute).
- Latency: one cycle. inst sampled at posedge t appears on d_* after posedge t.
- Register read is combinational from the file.
- Write-through bypass: if wb_en and wb_idx == read index (nonzero) in the same cycle, d_a/d_b carry wb_data.
- Register write occurs at posedge when wb_en=1 and wb_idx != 0. Writes to r0 are ignored. r0 always reads 0.
- Writeback is accepted every cycle, regardless of stall, flush or halted.
- Priority at posedge, highest first:
  - flush (do_branch|do_jump): all d_* = 0.
  - stall: hold all d_*.
  - halted: all d_* = 0.
  - else: decode inst.
- Flush beats stall when both are asserted in the same cycle.
- Bubble input (inst == 0): d_valid=0; other d_* = 0.
- Halt: instr == 16'hFFFF (not flushed, not stalled):
  - d_valid=1, d_op=1111, d_we=0; halted set at the same edge.
  - Afterwards: all d_* = 0 each cycle, input ignored.
  - Only reset clears halted.
  - A halt word arriving in a flush cycle is discarded; halted stays 0.
- Reset mid-operation: outputs and register file clear immediately. No partial writeback survives.

Test Plan:
- addi r1,1 (16'h5101) at pc 1, then addi r2,0x7F (16'h527F) at pc 2 → d_op=0101, d_rd=1, d_b=0x0001, d_we=1, d_pc=1; next cycle d_rd=2, d_b=0x007F, d_pc=2.
- Preload r2=5, r3=9 via wb; bgt r2,r3,-4 (16'hD23C) at pc 23 → d_a=5, d_b=9, d_is_branch=1, d_target=19. Repeat at pc 1 with off=1010 → d_target=507 (wrap).
- Same-cycle bypass: wb_en=1, wb_idx=4, wb_data=0xBEEF while add r4,r3 (16'h1430) decodes → d_a=0xBEEF. Write wb_idx=0, data 0x1234 → later reads of r0 return 0.
- Flush: do_branch=1 with valid add and stall=1 in the same cycle → next cycle d_valid=0, all d_* zero. Following cycle decodes the new inst normally.
- Halt: 16'hFFFF at pc 27 → d_valid=1, d_op=F, halted=1. Subsequent non-zero inst → d_valid stays 0. Halt word arriving together with do_jump=1 → halted stays 0.
- Async reset mid-stream: drop rst between clock edges after r5=0x00AA and a valid decode → all d_* and halted go 0 immediately. Reading r5 after release gives 0.

Source files
------------

// File: rtl/decode_stage.sv
// ============================================================================
// Module   : decode_stage
// Purpose  : Second pipeline stage: register file, decode, flush/stall/halt.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decode_stage #(
   parameter int AW   = 9,
   parameter int DW   = 16,
   parameter int NREG = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [AW+DW-1:0]        inst,
   input  logic                    do_branch,
   input  logic                    do_jump,
   input  logic                    stall,
   input  logic                    wb_en,
   input  logic [$clog2(NREG)-1:0] wb_idx,
   input  logic [DW-1:0]           wb_data,
   output logic                    d_valid,
   output logic [AW-1:0]           d_pc,
   output logic [3:0]              d_op,
   output logic [3:0]              d_rd,
   output logic [DW-1:0]           d_a,
   output logic [DW-1:0]           d_b,
   output logic                    d_we,
   output logic                    d_is_branch,
   output logic                    d_is_jump,
   output logic [AW-1:0]           d_target,
   output logic                    halted
);

   localparam logic [3:0]    c_OP_NOP  = 4'b0000;
   localparam logic [3:0]    c_OP_ADD  = 4'b0001;
   localparam logic [3:0]    c_OP_SUB  = 4'b0010;
   localparam logic [3:0]    c_OP_AND  = 4'b0011;
   localparam logic [3:0]    c_OP_OR   = 4'b0100;
   localparam logic [3:0]    c_OP_ADDI = 4'b0101;
   localparam logic [3:0]    c_OP_SUBI = 4'b0110;
   localparam logic [3:0]    c_OP_BGT  = 4'b1101;
   localparam logic [3:0]    c_OP_JMP  = 4'b1110;
   localparam logic [DW-1:0] c_HALT    = '1;
   localparam int            c_RW      = $clog2(NREG);

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] pc;
      logic [3:0]    op;
      logic [3:0]    rd;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic          we;
      logic          is_branch;
      logic          is_jump;
      logic [AW-1:0] target;
   } dec_t;

   logic [DW-1:0] r_regs [NREG];
   dec_t          r_out;
   logic          r_halted;

   logic [AW-1:0] w_pc;
   logic [DW-1:0] w_instr;
   logic [3:0]    w_opc;
   logic [3:0]    w_ra;
   logic [3:0]    w_rb;
   logic [DW-1:0] w_rdata_a;
   logic [DW-1:0] w_rdata_b;
   logic          w_flush;
   logic          w_bubble;
   logic          w_is_halt;
   logic          w_is_rtype;
   logic          w_is_imm;
   dec_t          w_dec;

   assign w_pc      = inst[AW+DW-1:DW];
   assign w_instr   = inst[DW-1:0];
   assign w_opc     = w_instr[15:12];
   assign w_ra      = w_instr[11:8];
   assign w_rb      = w_instr[7:4];
   assign w_flush   = do_branch | do_jump;
   assign w_bubble  = (inst == '0);
   assign w_is_halt = (w_instr == c_HALT);

   // Read port with write-through bypass; index 0 is hard-wired to zero.
   function automatic logic [DW-1:0] f_read(
      input logic [3:0]      idx,
      input logic [DW-1:0]   stored,
      input logic            byp_en,
      input logic [c_RW-1:0] byp_idx,
      input logic [DW-1:0]   byp_data
   );
      logic [DW-1:0] val;
      val = stored;
      if (idx == 4'd0)
         val = '0;
      else if (byp_en && (byp_idx == idx))
         val = byp_data;
      return val;
   endfunction

   assign w_rdata_a = f_read(w_ra, r_regs[w_ra], wb_en, wb_idx, wb_data);
   assign w_rdata_b = f_read(w_rb, r_regs[w_rb], wb_en, wb_idx, wb_data);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++)
            r_regs[i] <= '0;
      end else if (wb_en && (wb_idx != '0)) begin
         r_regs[wb_idx] <= wb_data;
      end
   end

   always_comb begin
      w_is_rtype = (w_opc == c_OP_ADD) || (w_opc == c_OP_SUB) ||
                   (w_opc == c_OP_AND) || (w_opc == c_OP_OR);
      w_is_imm   = (w_opc == c_OP_ADDI) || (w_opc == c_OP_SUBI);
   end

   always_comb begin
      w_dec           = '0;
      w_dec.valid     = 1'b1;
      w_dec.pc        = w_pc;
      w_dec.op        = w_opc;
      w_dec.rd        = w_ra;
      w_dec.a         = w_rdata_a;
      w_dec.we        = (w_is_rtype || w_is_imm) && (w_ra != 4'd0);
      w_dec.is_branch = (w_opc == c_OP_BGT);
      w_dec.is_jump   = (w_opc == c_OP_JMP);
      if (w_is_rtype || (w_opc == c_OP_BGT))
         w_dec.b = w_rdata_b;
      else if (w_is_imm)
         w_dec.b = {{(DW-8){1'b0}}, w_instr[7:0]};
      case (w_opc)
         // Branch offset is a signed 4-bit displacement; the sum wraps in AW bits.
         c_OP_BGT: w_dec.target = w_pc + {{(AW-4){w_instr[3]}}, w_instr[3:0]};
         c_OP_JMP: w_dec.target = w_instr[AW-1:0];
         c_OP_NOP: w_dec.target = '0;
         default:  w_dec.target = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out    <= '0;
         r_halted <= 1'b0;
      end else if (w_flush) begin
         r_out <= '0;
      end else if (stall) begin
         r_out <= r_out;
      end else if (r_halted || w_bubble) begin
         r_out <= '0;
      end else begin
         r_out <= w_dec;
         if (w_is_halt)
            r_halted <= 1'b1;
      end
   end

   assign d_valid     = r_out.valid;
   assign d_pc        = r_out.pc;
   assign d_op        = r_out.op;
   assign d_rd        = r_out.rd;
   assign d_a         = r_out.a;
   assign d_b         = r_out.b;
   assign d_we        = r_out.we;
   assign d_is_branch = r_out.is_branch;
   assign d_is_jump   = r_out.is_jump;
   assign d_target    = r_out.target;
   assign halted      = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Scoreboard bench for decode_stage using directed vectors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_decode_stage;

   typedef struct {
      logic [62:0] v;
      string       nm;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [24:0] inst;
   logic        do_branch;
   logic        do_jump;
   logic        stall;
   logic        wb_en;
   logic [3:0]  wb_idx;
   logic [15:0] wb_data;
   logic        d_valid;
   logic [8:0]  d_pc;
   logic [3:0]  d_op;
   logic [3:0]  d_rd;
   logic [15:0] d_a;
   logic [15:0] d_b;
   logic        d_we;
   logic        d_is_branch;
   logic        d_is_jump;
   logic [8:0]  d_target;
   logic        halted;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   decode_stage dut (
      .clk         (clk),
      .rst         (rst),
      .inst        (inst),
      .do_branch   (do_branch),
      .do_jump     (do_jump),
      .stall       (stall),
      .wb_en       (wb_en),
      .wb_idx      (wb_idx),
      .wb_data     (wb_data),
      .d_valid     (d_valid),
      .d_pc        (d_pc),
      .d_op        (d_op),
      .d_rd        (d_rd),
      .d_a         (d_a),
      .d_b         (d_b),
      .d_we        (d_we),
      .d_is_branch (d_is_branch),
      .d_is_jump   (d_is_jump),
      .d_target    (d_target),
      .halted      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [62:0] ex(
      input logic v, input logic [8:0] pc, input logic [3:0] op, input logic [3:0] rd,
      input logic [15:0] a, input logic [15:0] b, input logic we, input logic br,
      input logic jp, input logic [8:0] tg, input logic h
   );
      return {v, pc, op, rd, a, b, we, br, jp, tg, h};
   endfunction

   function automatic logic [62:0] actual();
      return {d_valid, d_pc, d_op, d_rd, d_a, d_b, d_we, d_is_branch, d_is_jump,
              d_target, halted};
   endfunction

   task automatic check(input string nm, input logic [62:0] act, input logic [62:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Monitor: one expectation per issued cycle, sampled 1ns after the edge.
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check(e.nm, actual(), e.v);
      end
   end

   task automatic step(
      input logic [8:0] pc, input logic [15:0] ins, input logic br, input logic jp,
      input logic st, input logic we, input logic [3:0] wi, input logic [15:0] wd,
      input logic [62:0] e, input string nm
   );
      exp_t item;
      inst      = {pc, ins};
      do_branch = br;
      do_jump   = jp;
      stall     = st;
      wb_en     = we;
      wb_idx    = wi;
      wb_data   = wd;
      item.v    = e;
      item.nm   = nm;
      q.push_back(item);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; inst = '0; do_branch = 1'b0; do_jump = 1'b0; stall = 1'b0;
      wb_en = 1'b0; wb_idx = '0; wb_data = '0;
      repeat (2) @(negedge clk);
      check("reset_state", actual(), 63'h0);
      rst = 1'b1;

      step(9'd1,  16'h5101, 0,0,0, 0,4'd0,16'h0000, ex(1,9'd1,4'h5,4'd1,16'h0,16'h0001,1,0,0,9'd0,0), "addi_r1");
      step(9'd2,  16'h527F, 0,0,0, 0,4'd0,16'h0000, ex(1,9'd2,4'h5,4'd2,16'h0,16'h007F,1,0,0,9'd0,0), "addi_r2");
      step(9'd0,  16'h0000, 0,0,0, 1,4'd2,16'h0005, 63'h0, "bubble_wb_r2");
      step(9'd0,  16'h0000, 0,0,0, 1,4'd3,16'h0009, 63'h0, "bubble_wb_r3");
      step(9'd23, 16'hD23C, 0,0,0, 0,4'd0,16'h0000, ex(1,9'd23,4'hD,4'd2,16'd5,16'd9,0,1,0,9'd19,0), "bgt_back");
      step(9'd1,  16'hD23A, 0,0,0, 0,4'd0,16'h0000, ex(1,9'd1,4'hD,4'd2,16'd5,16'd9,0,1,0,9'd507,0), "bgt_wrap");
      step(9'd5,  16'h1430, 0,0,0, 1,4'd4,16'hBEEF, ex(1,9'd5,4'h1,4'd4,16'hBEEF,16'd9,1,0,0,9'd0,0), "add_bypass");
      step(9'd6,  16'h1000, 0,0,0, 1,4'd0,16'h1234, ex(1,9'd6,4'h1,4'd0,16'h0,16'h0,0,0,0,9'd0,0), "r0_wb_ignored");
      step(9'd7,  16'h1040, 0,0,0, 0,4'd0,16'h0000, ex(1,9'd7,4'h1,4'd0,16'h0,16'hBEEF,0,0,0,9'd0,0), "r4_committed");
      step(9'd8,  16'h1430, 1,0,1, 0,4'd0,16'h0000, 63'h0, "flush_over_stall");
      step(9'd9,  16'h1320, 0,0,0, 0,4'd0,16'h0000, ex(1,9'd9,4'h1,4'd3,16'd9,16'd5,1,0,0,9'd0,0), "after_flush");
      step(9'd10, 16'h1230, 0,0,1, 0,4'd0,16'h0000, ex(1,9'd9,4'h1,4'd3,16'd9,16'd5,1,0,0,9'd0,0), "stall_hold");
      step(9'd11, 16'hE1C8, 0,0,0, 1,4'd5,16'h00AA, ex(1,9'd11,4'hE,4'd1,16'h0,16'h0,0,0,1,9'h1C8,0), "jmp_abs");

      // Asynchronous reset between edges must clear outputs at once.
      inst = '0; wb_en = 1'b0;
      #2 rst = 1'b0;
      #1 check("async_reset", actual(), 63'h0);
      @(negedge clk);
      rst = 1'b1;

      step(9'd13, 16'h1550, 0,0,0, 0,4'd0,16'h0000, ex(1,9'd13,4'h1,4'd5,16'h0,16'h0,1,0,0,9'd0,0), "r5_cleared");
      step(9'd12, 16'hFFFF, 0,1,0, 0,4'd0,16'h0000, 63'h0, "halt_flushed");
      step(9'd27, 16'hFFFF, 0,0,0, 0,4'd0,16'h0000, ex(1,9'd27,4'hF,4'hF,16'h0,16'h0,0,0,0,9'd0,1), "halt");
      step(9'd28, 16'h1320, 0,0,0, 0,4'd0,16'h0000, 63'h1, "halted_ignore");
      step(9'd29, 16'h5101, 0,0,0, 1,4'd6,16'h0042, 63'h1, "halted_ignore2");

      inst = '0; wb_en = 1'b0;
      @(negedge clk);
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end

      #2 rst = 1'b0;
      #1 check("reset_clears_halt", actual(), 63'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
